// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and default rates shared by the
// UART receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  typedef logic [7:0] uart_byte_t;

  localparam int CLK_HZ_DEF  = 100_000_000;
  localparam int BAUD_RT_DEF = 115200;

endpackage

// File: rtl/uart_receive_if.sv
// uart_receive_if: serial line in, received byte and status out.
// master = receiver side, slave = line driver / byte consumer.
interface uart_receive_if;
  import uart_pkg::*;

  logic       rx_serial;
  uart_byte_t rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;

  modport master (
    input  rx_serial,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output rx_frame_err
  );

  modport slave (
    output rx_serial,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  rx_frame_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the async line plus a
// falling-edge detector; all flops reset to the idle level 1.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_serial,
  output logic rx_sync,
  output logic rx_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // two synchroniser stages then one history flop for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_serial;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_sync = sync_q;
  assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receive.sv
// uart_receive: 8N1 UART receiver with mid-bit sampling.
// Stop-bit checking enabled by macro UART_RX_FRAME_ERR_EN.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = CLK_HZ_DEF,
  parameter int BAUD_RT   = BAUD_RT_DEF,
  parameter int DATA_BITS = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_receive_if.master bus
);

  localparam int CPB  = CLK_HZ / BAUD_RT;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  logic rx_sync;
  logic rx_fall;

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  uart_byte_t    shift_q, shift_d;
  uart_byte_t    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .rx_serial(bus.rx_serial),
    .rx_sync  (rx_sync),
    .rx_fall  (rx_fall)
  );

  // state, counters, shifter and registered output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // next state: find start, sample mid-bit, check stop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_fall) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_sync ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
`else
          data_d  = shift_q;
          valid_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_busy      = (state_q != IDLE);
  assign bus.rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: random and directed frames against a
// frame-level model of expected pulses and held data.
module tb_uart_receive;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD_RT = 50_000;
  localparam int CPB     = CLK_HZ / BAUD_RT;
  localparam int HALF    = CPB / 2;
  localparam int LAT     = 3 + HALF + 9 * CPB;

  typedef struct {
    bit         err;
    logic [7:0] d;
    longint     due;
  } exp_t;

  logic clk;
  logic reset;
  uart_receive_if bus ();

  uart_receive #(
    .CLK_HZ   (CLK_HZ),
    .BAUD_RT  (BAUD_RT),
    .DATA_BITS(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int     vectors    = 0;
  int     miscompares = 0;
  longint cyc        = 0;
  bit     started    = 0;
  exp_t   q[$];
  logic [7:0] mdl_data = 8'h00;
  longint first_t0   = -1;
  longint first_pulse = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, bit ok, longint act, longint exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               n, act, exp, cyc);
    end
  endtask

  task automatic chk_eq(string n, longint act, longint exp);
    chk(n, act == exp, act, exp);
  endtask

  // compare process: pulses vs expectation queue, data held
  always @(negedge clk) begin
    if (started) begin
      if (reset) begin
        q.delete();
        mdl_data = 8'h00;
      end else begin
        if (bus.rx_valid || bus.rx_frame_err) begin
          if (q.size() == 0) begin
            chk("spurious_pulse", 0,
                {bus.rx_valid, bus.rx_frame_err}, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk_eq("pulse_kind", {bus.rx_valid, bus.rx_frame_err},
                   e.err ? 2'b01 : 2'b10);
            chk("pulse_time", (cyc >= e.due - 1) && (cyc <= e.due + 1),
                cyc, e.due);
            if (!e.err) mdl_data = e.d;
            if (first_pulse < 0) first_pulse = cyc;
          end
          chk_eq("busy_at_pulse", bus.rx_busy, 0);
        end else if (q.size() != 0 && cyc > q[0].due + 1) begin
          chk("missing_pulse", 0, cyc, q[0].due);
          void'(q.pop_front());
        end
        chk_eq("rx_data_hold", bus.rx_data, mdl_data);
      end
    end
  end

  task automatic hold(logic v, int n);
    bus.rx_serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stop_bits: length of stop level in bit times; abort_bit >= 0
  // pulses reset in the middle of that data bit and drops the frame
  task automatic send(logic [7:0] d, logic stopb, int stop_bits,
                      int abort_bit);
    exp_t e;
    longint t0;
    t0 = cyc + 1;
    if (first_t0 < 0) first_t0 = t0;
`ifdef UART_RX_FRAME_ERR_EN
    e.err = !stopb;
`else
    e.err = 1'b0;
`endif
    e.d   = d;
    e.due = t0 + LAT;
    q.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        hold(d[i], CPB / 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.rx_serial = 1'b1;
        return;
      end
      hold(d[i], CPB);
    end
    hold(stopb, CPB * stop_bits);
    bus.rx_serial = 1'b1;
  endtask

  task automatic glitch(int len);
    hold(1'b0, len);
    hold(1'b1, HALF + 8);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    bus.rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_eq("rst_data", bus.rx_data, 8'h00);
    chk_eq("rst_valid", bus.rx_valid, 0);
    chk_eq("rst_busy", bus.rx_busy, 0);
    chk_eq("rst_ferr", bus.rx_frame_err, 0);
    started = 1;
    hold(1'b1, 5);

    send(8'hA5, 1'b1, 1, -1);
    hold(1'b1, 3 * CPB);
    chk_eq("a5_data", bus.rx_data, 8'hA5);
    chk_eq("a5_busy", bus.rx_busy, 0);
    chk("a5_latency",
        (first_pulse - first_t0 >= 192) && (first_pulse - first_t0 <= 194),
        first_pulse - first_t0, 193);

    bus.rx_serial = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.rx_serial = 1'b1;
    chk_eq("glitch_busy_hi", bus.rx_busy, 1);
    hold(1'b1, HALF + 4);
    chk_eq("glitch_busy_lo", bus.rx_busy, 0);
    chk_eq("glitch_data", bus.rx_data, 8'hA5);

    send(8'h3C, 1'b0, 1, -1);
    hold(1'b1, 2 * CPB);
`ifdef UART_RX_FRAME_ERR_EN
    chk_eq("ferr_data", bus.rx_data, 8'hA5);
`else
    chk_eq("ferr_data", bus.rx_data, 8'h3C);
`endif

    send(8'h00, 1'b1, 1, -1);
    send(8'hFF, 1'b1, 1, -1);
    hold(1'b1, 2 * CPB);
    chk_eq("b2b_data", bus.rx_data, 8'hFF);

    send(8'h81, 1'b1, 1, 4);
    chk_eq("abort_data", bus.rx_data, 8'h00);
    chk_eq("abort_valid", bus.rx_valid, 0);
    chk_eq("abort_busy", bus.rx_busy, 0);
    chk_eq("abort_ferr", bus.rx_frame_err, 0);
    hold(1'b1, CPB);
    send(8'h55, 1'b1, 1, -1);
    hold(1'b1, 2 * CPB);
    chk_eq("after_abort", bus.rx_data, 8'h55);

    send(8'h3C, 1'b0, 21, -1);
    hold(1'b1, 2 * CPB);
    send(8'h12, 1'b1, 1, -1);
    hold(1'b1, 2 * CPB);
    chk_eq("after_break", bus.rx_data, 8'h12);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        glitch($urandom_range(1, HALF - 2));
      end else begin
        logic [7:0] d;
        bit bad;
        d = 8'($urandom());
        bad = ($urandom_range(0, 5) == 0);
        send(d, !bad, bad ? $urandom_range(1, 3) : 1, -1);
        w = bad ? $urandom_range(3, CPB) : $urandom_range(0, 5);
        if (w > 0) hold(1'b1, w);
      end
    end

    w = 0;
    while (q.size() != 0 && w < 12 * CPB) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk_eq("drain_queue", q.size(), 0);
    hold(1'b1, 4);
    started = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
# uart_receive

Asynchronous serial receiver for 8N1 UART frames. It is the receive-side counterpart of the design's UART transmitter. It synchronises the incoming line into the `clk` domain, detects a start bit, samples each data bit at mid-bit, and checks the stop bit. Each complete byte is presented as a one-cycle `rx_valid` pulse to the downstream consumer (command parser / FIFO).

## Interface
Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BAUD_RT, 115200: line baud rate.
- DATA_BITS, 8: data bits per frame; only 8 is supported.

Derived constants:
- CYCLES_PER_BIT = CLK_HZ/BAUD_RT (integer division; 868 at defaults).
- HALF_BIT = CYCLES_PER_BIT/2 (434 at defaults).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- rx_serial  in  1  asynchronous serial line; idles high.
- rx_data  out  8  last correctly received byte, LSB first on the line.
- rx_valid  out  1  one-cycle pulse; `rx_data` is new this cycle.
- rx_busy  out  1  high whenever the state is not IDLE.
- rx_frame_err  out  1  one-cycle pulse on a bad stop bit.

## Operation
- `rx_serial` passes through a 2-flop synchroniser. Both flops reset to 1. A third flop holds the previous synchronised value for falling-edge detection.
- Cycle counter width is $clog2(CYCLES_PER_BIT). Bit counter is 3 bits. The shift register is 8 bits, with each new bit shifted in at the MSB (right shift), so the result is LSB-first.
- States:
  - IDLE: counters are held at 0. On a synchronised falling edge (previous 1, current 0), go to START with the cycle counter at 0.
  - START: the cycle counter increments. When it reaches HALF_BIT-1, sample the line:
    - sample = 0: go to DATA and clear the cycle counter.
    - sample = 1: glitch. Go back to IDLE with no output.
  - DATA: the cycle counter increments. When it reaches CYCLES_PER_BIT-1, clear it, shift in the sample, and increment the bit counter. After the 8th bit (bit counter = 7), go to STOP.
  - STOP: when the cycle counter reaches CYCLES_PER_BIT-1, sample the stop bit and go to IDLE:
    - sample = 1: load `rx_data` from the shift register and pulse `rx_valid`.
    - sample = 0: frame error (see Configuration).
- `rx_data` holds its value until the next valid frame. It is never modified on a glitch or a frame error.
- A line held low after a frame error (break) does not retrigger reception. IDLE requires a falling edge, so the line must first return high.
- Only one stop bit is checked. A new start edge is accepted in the first cycle back in IDLE, which supports back-to-back frames.

## Timing
- Reset values: rx_data = 0x00, rx_valid = 0, rx_busy = 0, rx_frame_err = 0, state = IDLE, synchroniser flops = 1.
- Synchroniser latency is 2 cycles. Falling-edge detection adds 1 cycle.
- `rx_valid` and `rx_frame_err` are registered and asserted in the cycle after the stop-sample edge, for exactly 1 cycle.
- From the first low `clk` sample of the start bit to `rx_valid` high: 3 + HALF_BIT + 9·CYCLES_PER_BIT cycles, ±1.
- `rx_busy` rises the cycle after edge detection. It falls in the same cycle that `rx_valid` or `rx_frame_err` pulses, or on a START glitch.
- Reset asserted mid-frame abandons the frame. All outputs take their reset values on the next edge, and no pulse is generated.
- There is no back-pressure. The consumer must capture `rx_data` before the next `rx_valid`.

## Configuration
Macro `UART_RX_FRAME_ERR_EN`:
- Defined: a stop-bit sample of 0 pulses `rx_frame_err`, suppresses `rx_valid`, and leaves `rx_data` unchanged.
- Undefined: the stop bit is not checked. `rx_valid` pulses and `rx_data` loads regardless of the stop bit, and `rx_frame_err` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - State encodings IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11, shared with the transmitter.
  - Default CLK_HZ and BAUD_RT constants.
- One sub-module, `uart_rx_sync`: the 2-flop synchroniser plus falling-edge detector. It outputs `rx_sync` and `rx_fall`, with the flops resetting to 1.

## Test plan
- Send frame 0xA5 at the defaults (868 cycles/bit, 8N1) → `rx_valid` high for 1 cycle, `rx_data` = 0xA5, `rx_frame_err` = 0, `rx_busy` low afterwards.
- Drive a low glitch for 200 cycles, then hold the line high → no `rx_valid`, `rx_busy` returns to 0 by cycle ~437, `rx_data` unchanged.
- Send 0x3C with stop bit = 0:
  - with `UART_RX_FRAME_ERR_EN` → 1-cycle `rx_frame_err`, no `rx_valid`, `rx_data` keeps its prior value.
  - without it → `rx_valid` pulses with `rx_data` = 0x3C.
- Send back-to-back 0x00 then 0xFF, with the second start bit immediately after the first stop bit → two `rx_valid` pulses, data 0x00 then 0xFF.
- Assert reset for 1 cycle during data bit 4 of 0x81, then send 0x55 → all outputs at reset values with no pulse for the aborted frame; the next frame yields `rx_data` = 0x55.
- Hold the line low for 20 bit times after a frame error, then release and send 0x12 → no spurious frames during the low period; `rx_data` = 0x12.
